// File: rtl/tick_divider_ctrl.sv
// Four-channel clock-enable / square-wave generator with start, run and graceful stop.
// Divisors are written through a shadow register per channel and only take effect at a
// period boundary, so a channel never emits a shortened or stretched period.
module tick_divider_ctrl #(
  parameter int CW = 32,
  parameter logic [CW-1:0] DEF_DIV0 = CW'(50_000),
  parameter logic [CW-1:0] DEF_DIV1 = CW'(500_000),
  parameter logic [CW-1:0] DEF_DIV2 = CW'(5_000_000),
  parameter logic [CW-1:0] DEF_DIV3 = CW'(50_000_000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_ch,
  input  logic [CW-1:0] cfg_div,
  output logic          run,
  output logic [3:0]    tick,
  output logic [3:0]    clk_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [CW-1:0] MIN_DIV = CW'(2);
  localparam logic [CW-1:0] DEF_DIV [4] = '{DEF_DIV0, DEF_DIV1, DEF_DIV2, DEF_DIV3};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [CW-1:0] div_q  [4];
  logic [CW-1:0] div_d  [4];
  logic [CW-1:0] pend_q [4];
  logic [CW-1:0] pend_d [4];
  logic [3:0]    pend_vld_q, pend_vld_d;
  logic [3:0]    done_q, done_d;
  logic [3:0]    tick_q, tick_d;
  logic [3:0]    clk_out_q, clk_out_d;
  logic          cfg_accept;
  logic          chan_live;

  assign cfg_ready  = ~pend_vld_q[cfg_ch];
  assign cfg_accept = cfg_valid & cfg_ready;
  assign run        = (state_q != IDLE);
  assign tick       = tick_q;
  assign clk_out    = clk_out_q;

  // Next-state: sequencing FSM, per-channel counters, divisor swap at wrap, config capture.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    done_d     = done_q;
    tick_d     = '0;
    clk_out_d  = '0;
    chan_live  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pend_d[i] = pend_q[i];
    end

    case (state_q)
      IDLE: begin
        for (int i = 0; i < 4; i++) begin
          cnt_d[i] = '0;
          if (pend_vld_q[i]) begin
            div_d[i]      = pend_q[i];
            pend_vld_d[i] = 1'b0;
          end
        end
        if (start) begin
          state_d = RUN;
          // First active cycle: cnt=0 with the divisor that is about to be in force.
          for (int i = 0; i < 4; i++) begin
            tick_d[i]    = (div_d[i] == CW'(1));
            clk_out_d[i] = (div_d[i] >> 1) != '0;
          end
        end
      end

      RUN, STOP: begin
        for (int i = 0; i < 4; i++) begin
          chan_live = (state_q == RUN) || !done_q[i];
          if (chan_live) begin
            if (cnt_q[i] == div_q[i] - CW'(1)) begin
              cnt_d[i] = '0;
              if (pend_vld_q[i]) begin
                div_d[i]      = pend_q[i];
                pend_vld_d[i] = 1'b0;
              end
              // In STOP the channel parks once its current period has finished.
              if (state_q == STOP) done_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (!done_d[i]) begin
              tick_d[i]    = (cnt_d[i] == div_d[i] - CW'(1));
              clk_out_d[i] = (cnt_d[i] < (div_d[i] >> 1));
            end
          end
        end
        if (state_q == RUN) begin
          if (stop) state_d = STOP;
        end else if (&done_q) begin
          state_d = IDLE;
          done_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A write can never collide with a swap on the same channel: swap needs pend_vld set,
    // acceptance needs it clear.
    if (cfg_accept) begin
      pend_d[cfg_ch]     = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
      pend_vld_d[cfg_ch] = 1'b1;
    end
  end

  // State registers; reset also restores the default divisors and drops pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_vld_q <= '0;
      done_q     <= '0;
      tick_q     <= '0;
      clk_out_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DEF_DIV[i];
        pend_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

endmodule
